// File: rtl/rr_burst_grant_ctrl_pkg.sv
// Shared types and helpers for the burst grant controller and its round-robin core.
package rr_burst_grant_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Minimum 1 so a 1-bit index still has a legal width.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic [31:0] onehot2bin(input logic [255:0] v);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 256; i++)
      if (v[i]) idx = idx | 32'(i);
    return idx;
  endfunction

endpackage

// File: rtl/gen_round_robin.sv
// Round-robin / strict-priority selector. The pointer only moves when arb is pulsed,
// so the caller decides what counts as one fairness turn.
module gen_round_robin
  import rr_burst_grant_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] in,
  input  logic         sp,
  input  logic         arb,
  input  logic         restart,
  input  logic [W-1:0] restart_in,
  output logic [W-1:0] select,
  output logic [W-1:0] last
);

  localparam int IW = clog2(W);

  logic [W-1:0]  base;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          found;

  // A restart vector is advanced one position before use, so the search resumes
  // two places past the requester named by restart_in.
  always_comb begin
    base = restart ? {restart_in[W-2:0], restart_in[W-1]} : last;
    ptr = '0;
    for (int i = 0; i < W; i++)
      if (base[i]) ptr = IW'(i);
    select = '0;
    found  = 1'b0;
    idx    = '0;
    if (sp) begin
      for (int i = 0; i < W; i++)
        if (in[i] && !found) begin
          select[i] = 1'b1;
          found     = 1'b1;
        end
    end else begin
      for (int k = 1; k <= W; k++) begin
        idx = IW'((int'(ptr) + k) % W);
        if (in[idx] && !found) begin
          select[idx] = 1'b1;
          found       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               last <= W'(1);
    else if (arb && |select)    last <= select;
  end

endmodule

// File: rtl/rr_burst_grant_ctrl.sv
// Burst grant controller: takes an owner from the RR core, holds a one-hot grant for a
// burst and releases on last beat, quantum expiry or request drop.
module rr_burst_grant_ctrl
  import rr_burst_grant_ctrl_pkg::*;
#(
  parameter int W   = 8,
  parameter int QW  = 8,
  parameter int IDW = clog2(W)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic           sp_mode,
  input  logic [W-1:0]   req,
  input  logic           restart,
  input  logic [W-1:0]   restart_in,
  input  logic [QW-1:0]  quantum_cfg,
  input  logic           beat,
  input  logic           last_beat,
  output logic [W-1:0]   gnt,
  output logic           gnt_vld,
  output logic [IDW-1:0] owner_id,
  output logic [QW-1:0]  beat_cnt,
  output logic           proto_err
);

  state_e         state, state_n;
  logic [W-1:0]   gnt_n;
  logic [IDW-1:0] owner_n;
  logic [QW-1:0]  cnt_n;
  logic           take;
  logic           rel;
  logic [W-1:0]   core_sel;
  logic [W-1:0]   core_last_unused;

  gen_round_robin #(.W(W)) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (req),
    .sp         (sp_mode),
    .arb        (take),
    .restart    (restart),
    .restart_in (restart_in),
    .select     (core_sel),
    .last       (core_last_unused)
  );

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner_id;
    cnt_n   = beat_cnt;
    take    = 1'b0;
    rel     = 1'b0;
    case (state)
      IDLE: begin
        if (en && |req) begin
          take    = 1'b1;
          state_n = OWN;
          gnt_n   = core_sel;
          owner_n = IDW'(onehot2bin(256'(core_sel)));
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (beat)
          cnt_n = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
        // >= rather than == so a quantum lowered mid-burst still releases on the next beat
        rel = (beat && last_beat) ||
              (beat && quantum_cfg != '0 &&
               ({1'b0, beat_cnt} + 1'b1) >= {1'b0, quantum_cfg}) ||
              (!req[owner_id] && !beat);
        if (rel) begin
          state_n = IDLE;
          gnt_n   = '0;
          owner_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_vld   <= 1'b0;
      owner_id  <= '0;
      beat_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_vld  <= |gnt_n;
      owner_id <= owner_n;
      beat_cnt <= cnt_n;
      if (beat && !gnt_vld) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_burst_grant_ctrl.sv
// Bench for rr_burst_grant_ctrl: directed scenarios plus randomized traffic against a
// requester-index level reference model.
module tb_rr_burst_grant_ctrl;
  localparam int W   = 8;
  localparam int QW  = 8;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           en, sp_mode, restart, beat, last_beat;
  logic [W-1:0]   req, restart_in;
  logic [QW-1:0]  quantum_cfg;
  logic [W-1:0]   gnt;
  logic           gnt_vld;
  logic [IDW-1:0] owner_id;
  logic [QW-1:0]  beat_cnt;
  logic           proto_err;

  int checks   = 0;
  int failures = 0;

  // reference model: owner index (-1 idle), beats counted, last winner, sticky error
  int m_owner, m_cnt, m_last;
  bit m_proto;

  logic [W+IDW+QW+1:0] dut_vec;
  assign dut_vec = {gnt, gnt_vld, owner_id, beat_cnt, proto_err};

  always #5 clk = ~clk;

  rr_burst_grant_ctrl #(.W(W), .QW(QW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sp_mode(sp_mode), .req(req),
    .restart(restart), .restart_in(restart_in), .quantum_cfg(quantum_cfg),
    .beat(beat), .last_beat(last_beat), .gnt(gnt), .gnt_vld(gnt_vld),
    .owner_id(owner_id), .beat_cnt(beat_cnt), .proto_err(proto_err)
  );

  function automatic logic [W+IDW+QW+1:0] exp_vec();
    logic [W-1:0] g;
    logic [IDW-1:0] o;
    g = (m_owner < 0) ? '0 : (W'(1) << m_owner);
    o = (m_owner < 0) ? '0 : IDW'(m_owner);
    return {g, (m_owner >= 0), o, QW'(m_cnt), m_proto};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_last = 0; m_proto = 1'b0;
  endtask

  task automatic model_step();
    int start, ri, winner;
    bit rel;
    if (beat && m_owner < 0) m_proto = 1'b1;
    if (m_owner < 0) begin
      if (en && req != '0) begin
        ri = 0;
        for (int i = 0; i < W; i++) if (restart_in[i]) ri = i;
        start  = restart ? (ri + 1) % W : m_last;
        winner = -1;
        if (sp_mode) begin
          for (int i = W - 1; i >= 0; i--) if (req[i]) winner = i;
        end else begin
          for (int k = W; k >= 1; k--) if (req[(start + k) % W]) winner = (start + k) % W;
        end
        m_owner = winner; m_last = winner; m_cnt = 0;
      end
    end else begin
      rel = 1'b0;
      if (beat) begin
        if (last_beat) rel = 1'b1;
        if (quantum_cfg != 0 && m_cnt + 1 >= int'(quantum_cfg)) rel = 1'b1;
        if (m_cnt < (1 << QW) - 1) m_cnt++;
      end else if (!req[m_owner]) rel = 1'b1;
      if (rel) m_owner = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b0; sp_mode = 1'b0; req = '0; restart = 1'b0; restart_in = '0;
    quantum_cfg = '0; beat = 1'b0; last_beat = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    checks++;
    if (dut_vec !== '0) begin
      failures++; $display("FAIL reset_state got=%h want=0", dut_vec);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1; req = 8'h05;
    step();
    checks++;
    if (gnt !== 8'h04 || owner_id !== 3'd2) begin
      failures++; $display("FAIL basic_first gnt=%h owner=%0d want gnt=04 owner=2", gnt, owner_id);
    end
    step();
    req = 8'h01;
    step();
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
      failures++; $display("FAIL basic_drop gnt=%h vld=%b want 00/0", gnt, gnt_vld);
    end
    step();
    checks++;
    if (gnt !== 8'h01 || owner_id !== 3'd0 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL basic_second got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_quantum();
    logic [W-1:0] prev, g[$];
    int len, lens[$];
    prev = '0; len = 0;
    do_reset();
    en = 1'b1; quantum_cfg = 8'd4; req = 8'hFF; beat = 1'b1;
    repeat (40) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL quantum_model got=%h want=%h", dut_vec, exp_vec());
      end
      if (gnt != '0 && prev == '0) begin g.push_back(gnt); len = 1; end
      else if (gnt != '0) len++;
      else if (prev != '0) lens.push_back(len);
      prev = gnt;
    end
    checks++;
    if (g.size() < 6 || lens.size() < 5) begin
      failures++; $display("FAIL quantum_count grants=%0d want>=6", g.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (g[k] !== (W'(2) << k)) begin
          failures++; $display("FAIL quantum_rotate idx=%0d got=%h want=%h", k, g[k], W'(2) << k);
        end
      end
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (lens[k] != 4) begin
          failures++; $display("FAIL quantum_len idx=%0d got=%0d want=4", k, lens[k]);
        end
      end
    end
    beat = 1'b0;
  endtask

  task automatic test_last_beat();
    do_reset();
    en = 1'b1; req = 8'h01;
    step();
    beat = 1'b1;
    step();
    checks++;
    if (beat_cnt !== 8'd1 || gnt !== 8'h01) begin
      failures++; $display("FAIL lastbeat_mid cnt=%0d gnt=%h want 1/01", beat_cnt, gnt);
    end
    last_beat = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h00 || beat_cnt !== 8'd2) begin
      failures++; $display("FAIL lastbeat_rel gnt=%h cnt=%0d want 00/2", gnt, beat_cnt);
    end
    beat = 1'b0; last_beat = 1'b0;
    step();
    checks++;
    if (gnt !== 8'h01 || beat_cnt !== 8'd0 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL lastbeat_regrant got=%h want=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_sp();
    int n;
    n = 0;
    do_reset();
    en = 1'b1; sp_mode = 1'b1; req = 8'h0A;
    repeat (20) begin
      beat = (m_owner >= 0); last_beat = beat;
      step();
      checks++;
      if (dut_vec !== exp_vec() || (gnt != '0 && gnt !== 8'h02)) begin
        failures++; $display("FAIL sp_grant got=%h want=%h", dut_vec, exp_vec());
      end
      if (gnt == 8'h02) n++;
    end
    checks++;
    if (n < 8) begin
      failures++; $display("FAIL sp_count got=%0d want>=8", n);
    end
    beat = 1'b0; last_beat = 1'b0; sp_mode = 1'b0;
  endtask

  task automatic test_restart();
    do_reset();
    en = 1'b1; req = 8'hFF; restart = 1'b1; restart_in = 8'h10;
    step();
    checks++;
    if (gnt !== 8'h40 || owner_id !== 3'd6) begin
      failures++; $display("FAIL restart_first gnt=%h want=40", gnt);
    end
    restart = 1'b0; beat = 1'b1; last_beat = 1'b1;
    step();
    beat = 1'b0; last_beat = 1'b0;
    step();
    checks++;
    if (gnt !== 8'h80 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL restart_next gnt=%h want=80", gnt);
    end
  endtask

  task automatic test_proto_reset();
    do_reset();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_sticky got=%b want=1", proto_err);
    end
    en = 1'b1; req = 8'h05;
    step();
    step();
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL async_reset gnt=%h vld=%b perr=%b want 00/0/0", gnt, gnt_vld, proto_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h04 || dut_vec !== exp_vec()) begin
      failures++; $display("FAIL post_reset gnt=%h want=04", gnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en          = ($urandom_range(0, 7) != 0);
      sp_mode     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) req = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) req = '0;
      restart     = ($urandom_range(0, 3) == 0);
      restart_in  = W'(1) << $urandom_range(0, W - 1);
      if ($urandom_range(0, 7) == 0) quantum_cfg = QW'($urandom_range(0, 5));
      beat        = $urandom_range(0, 1) != 0;
      last_beat   = ($urandom_range(0, 3) == 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h want=%h", c, dut_vec, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quantum();
    test_last_beat();
    test_sp();
    test_restart();
    test_proto_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
